// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-requester arbitrated multiplier: sizes,
// FSM state encoding and the arbitration pick function.
package mult_arb_pkg;

  localparam int NREQ = 2;
  localparam int DW   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-hot winner among the valid requesters. When both are valid, round-robin
  // picks the one not served last; fixed priority always picks requester 0.
  function automatic logic [NREQ-1:0] arb_pick(input logic [NREQ-1:0] valid,
                                               input logic            last,
                                               input logic            rr);
    logic [NREQ-1:0] g;
    g = '0;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (rr && !last) ? 2'b10 : 2'b01;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mult.sv
// Combinational signed multiplier returning the low W bits of the product
// (two's-complement wrap, no saturation).
module mult #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] p_o
);

  // Evaluated in a W-bit context, so only the low W product bits are formed.
  assign p_o = a_i * b_i;

endmodule

// File: rtl/mult_arb.sv
// Two requesters share one signed 8x8 multiplier through a three-state
// IDLE/EXEC/DONE controller.
//
// Handshakes: a request transfers on a clk edge where req_valid[i] and
// req_ready[i] are both 1; req_ready is only offered in IDLE, one-hot for the
// winner. A response is held (rsp_valid[grant], rsp_data stable) until
// rsp_ack[grant] is 1 at a clk edge; other ack bits are ignored.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic signed [DW-1:0] req0_a,
  input  logic signed [DW-1:0] req0_b,
  input  logic signed [DW-1:0] req1_a,
  input  logic signed [DW-1:0] req1_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ack,
  output logic signed [DW-1:0] rsp_data,
  output logic                 busy,
  output state_e               dbg_state
);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic signed [DW-1:0] a_q, a_d;
  logic signed [DW-1:0] b_q, b_d;
  logic signed [DW-1:0] data_q, data_d;
  logic [NREQ-1:0]     win;
  logic                hs;
  logic signed [DW-1:0] prod;

  mult #(.W(DW)) u_mult (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  assign win       = arb_pick(req_valid, last_q, RR_EN != 0);
  assign req_ready = (state_q == IDLE && !reset) ? win : '0;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          grant_d = win[1];
          last_d  = win[1];
          a_d     = win[1] ? req1_a : req0_a;
          b_d     = win[1] ? req1_b : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = prod;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ack[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Last-served resets to requester 1 so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = data_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_arb.sv
// Directed bench for mult_arb: a round-robin and a fixed-priority instance,
// checked through an expected-result queue filled at each handshake.
module tb_mult_arb;
  import mult_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] rv, ak;
  logic [7:0] a0, b0, a1, b1;
  logic       sel;

  logic [1:0] rv_r, ak_r, rv_f, ak_f;
  logic [1:0] rdy_r, rdy_f, vld_r, vld_f;
  logic [7:0] data_r, data_f;
  logic       busy_r, busy_f;
  state_e     st_r, st_f;

  logic [1:0] rdy, vld;
  logic [7:0] data;
  logic       busy;
  logic [1:0] st;

  assign rv_r = sel ? 2'b00 : rv;
  assign ak_r = sel ? 2'b00 : ak;
  assign rv_f = sel ? rv : 2'b00;
  assign ak_f = sel ? ak : 2'b00;
  assign rdy  = sel ? rdy_f  : rdy_r;
  assign vld  = sel ? vld_f  : vld_r;
  assign data = sel ? data_f : data_r;
  assign busy = sel ? busy_f : busy_r;
  assign st   = sel ? st_f   : st_r;

  mult_arb #(.RR_EN(1)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(rv_r), .req_ready(rdy_r),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .rsp_valid(vld_r), .rsp_ack(ak_r), .rsp_data(data_r),
    .busy(busy_r), .dbg_state(st_r)
  );

  mult_arb #(.RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(rv_f), .req_ready(rdy_f),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .rsp_valid(vld_f), .rsp_ack(ak_f), .rsp_data(data_f),
    .busy(busy_f), .dbg_state(st_f)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_g[$];
  logic       last_m[2];
  logic [7:0] last_data;
  logic       last_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mul8(input logic signed [7:0] x, input logic signed [7:0] y);
    logic signed [15:0] p;
    p = 16'(x) * 16'(y);
    return p[7:0];
  endfunction

  function automatic logic pick(input logic [1:0] v, input logic last, input logic rr);
    if (v == 2'b10) return 1'b1;
    if (v == 2'b01) return 1'b0;
    return rr ? ~last : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_m[0] = 1'b1;
    last_m[1] = 1'b1;
  endtask

  // One full transaction: offer, handshake, EXEC, DONE (+stall), ack.
  task automatic issue(input logic [1:0] v, input logic [7:0] x0, input logic [7:0] y0,
                       input logic [7:0] x1, input logic [7:0] y1, input int stall);
    logic       w, g;
    logic [1:0] oh;
    logic [7:0] held;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1; rv = v;
    #1;
    w  = pick(v, last_m[sel], sel == 1'b0);
    oh = w ? 2'b10 : 2'b01;
    check("req_ready", rdy, oh);
    exp_q.push_back(mul8(w ? x1 : x0, w ? y1 : y0));
    exp_g.push_back(w);
    last_m[sel] = w;
    tick();
    a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
    a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
    #1;
    check("exec_state", st, EXEC);
    check("exec_vld", vld, 2'b00);
    check("exec_ready", rdy, 2'b00);
    tick();
    g    = exp_g.pop_front();
    held = exp_q.pop_front();
    check("rsp_valid", vld, g ? 2'b10 : 2'b01);
    check("rsp_data", data, held);
    for (int i = 0; i < stall; i++) begin
      ak = ~oh;
      tick();
      check("stall_data", data, held);
      check("stall_ready", rdy, 2'b00);
      check("stall_busy", busy, 1'b1);
      check("stall_vld", vld, g ? 2'b10 : 2'b01);
    end
    last_data  = data;
    last_grant = g;
    ak = oh;
    tick();
    ak = 2'b00;
    rv = 2'b00;
    check("ack_idle", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rv = 2'b11; ak = 2'b00; sel = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    last_m[0] = 1'b1; last_m[1] = 1'b1;
    last_data = '0; last_grant = 1'b0;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_ready", rdy, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_vld", vld, 2'b00);
      check("rst_data", data, 8'h00);
      check("rst_state", st, IDLE);
    end
    rv = 2'b00; sel = 1'b0; reset = 1'b0;
    #1;

    issue(2'b01, 8'd3, 8'hFC, 8'd0, 8'd0, 0);
    check("spec_3x-4", last_data, 8'hF4);
    issue(2'b01, 8'd16, 8'd16, 8'd0, 8'd0, 0);
    check("trunc_16x16", last_data, 8'h00);
    issue(2'b10, 8'd1, 8'd1, 8'h80, 8'hFF, 0);
    check("trunc_-128x-1", last_data, 8'h80);
    check("single_req1_grant", last_grant, 1'b1);
    issue(2'b01, 8'd0, 8'hF9, 8'd0, 8'd0, 0);
    check("zero_operand", last_data, 8'h00);
    issue(2'b01, 8'd5, 8'd7, 8'd0, 8'd0, 5);

    // Withdrawn request: offered but dropped before the edge.
    rv = 2'b01;
    #1;
    check("withdraw_ready", rdy, 2'b01);
    rv = 2'b00;
    tick();
    check("withdraw_busy", busy, 1'b0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
      check("rr_alternate", last_grant, i[0]);
    end
    issue(2'b01, 8'd9, 8'd9, 8'd2, 8'd2, 0);
    check("rr_single_after_0", last_grant, 1'b0);

    // Reset while in EXEC discards the operation.
    rv = 2'b10; a1 = 8'd7; b1 = 8'd6;
    tick();
    rv = 2'b00;
    check("midop_exec", st, EXEC);
    reset = 1'b1;
    #1;
    check("midop_rst_ready", rdy, 2'b00);
    tick();
    reset = 1'b0;
    last_m[0] = 1'b1; last_m[1] = 1'b1;
    check("midop_state", st, IDLE);
    check("midop_vld", vld, 2'b00);
    check("midop_data", data, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midop_no_rsp", vld, 2'b00);
    end
    issue(2'b11, 8'd4, 8'd5, 8'd6, 8'd7, 0);
    check("midop_next_grant", last_grant, 1'b0);

    sel = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
      check("fixed_grant", last_grant, 1'b0);
    end
    issue(2'b10, 8'd3, 8'd3, 8'hFD, 8'd5, 1);
    check("fixed_single_req1", last_grant, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
